// File: rtl/clic_irq_sequencer_if.sv
// Handshake bundle between the CLIC arbiter/write port, the core trap logic and the
// interrupt sequencer; the sequencer connects through the slave modport.
interface clic_irq_sequencer_if #(
   parameter int NEST_DEPTH = 4,
   parameter int ID_W       = 5,
   parameter int LVL_W      = 8
);
   localparam int DW = $clog2(NEST_DEPTH + 1);

   logic             irq_valid;
   logic [ID_W-1:0]  irq_id;
   logic [LVL_W-1:0] irq_level;
   logic             irq_edge;
   logic             irq_busy;
   logic             trap_req;
   logic [ID_W-1:0]  trap_id;
   logic [LVL_W-1:0] trap_level;
   logic             trap_ack;
   logic             mret;
   logic             clr_valid;
   logic [ID_W-1:0]  clr_id;
   logic             clr_ready;
   logic [LVL_W-1:0] cur_level;
   logic [ID_W-1:0]  cur_id;
   logic [DW-1:0]    depth;
   logic             err_underflow;
   logic             err_timeout;

   // Arbiter, core and CLIC side of the bundle.
   modport master (
      output irq_valid, irq_id, irq_level, irq_edge, trap_ack, mret, clr_ready,
      input  irq_busy, trap_req, trap_id, trap_level, clr_valid, clr_id,
             cur_level, cur_id, depth, err_underflow, err_timeout
   );

   modport slave (
      input  irq_valid, irq_id, irq_level, irq_edge, trap_ack, mret, clr_ready,
      output irq_busy, trap_req, trap_id, trap_level, clr_valid, clr_id,
             cur_level, cur_id, depth, err_underflow, err_timeout
   );
endinterface

// File: rtl/clic_irq_sequencer.sv
// CLIC interrupt entry/exit sequencer with a nested level/ID stack.
// Optional trap_ack timeout enabled by defining CLIC_SEQ_TIMEOUT_EN.
module clic_irq_sequencer #(
   parameter int NEST_DEPTH  = 4,
   parameter int ID_W        = 5,
   parameter int LVL_W       = 8,
   parameter int ACK_TIMEOUT = 64
) (
   input logic                   clk,
   input logic                   resetb,
   clic_irq_sequencer_if.slave   bus
);
   localparam int DW = $clog2(NEST_DEPTH + 1);
   localparam int AW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

   typedef enum logic [1:0] {READY = 2'd0, REQ = 2'd1, CLR = 2'd2} state_t;

   state_t           state;
   state_t           state_nx;

   logic [LVL_W-1:0] cur_level;
   logic [ID_W-1:0]  cur_id;
   logic [DW-1:0]    depth;
   logic             err_underflow;
   logic             err_timeout;

   logic [LVL_W-1:0] lat_level;
   logic [ID_W-1:0]  lat_id;
   logic             lat_edge;

   logic [LVL_W-1:0] stack_lvl [NEST_DEPTH];
   logic [ID_W-1:0]  stack_id  [NEST_DEPTH];

   logic             accept;
   logic             do_pop;
   logic             do_push;
   logic [DW-1:0]    depth_pop;
   logic [LVL_W-1:0] lvl_pop;
   logic [ID_W-1:0]  id_pop;
   logic [AW-1:0]    pop_idx;
   logic [AW-1:0]    push_idx;
   logic             ack_expired;

   logic             irq_busy;
   logic             trap_req;
   logic [ID_W-1:0]  trap_id;
   logic [LVL_W-1:0] trap_level;
   logic             clr_valid;
   logic [ID_W-1:0]  clr_id;

   // Pop is resolved before push so an mret coinciding with trap_ack nets out to a swap.
   always_comb begin
      accept    = (state == READY) && !bus.mret && bus.irq_valid &&
                  (bus.irq_level > cur_level) && (depth < DW'(NEST_DEPTH));
      do_pop    = bus.mret && (depth != '0);
      do_push   = (state == REQ) && bus.trap_ack;
      pop_idx   = AW'(depth - DW'(1));
      depth_pop = do_pop ? depth - DW'(1) : depth;
      lvl_pop   = do_pop ? stack_lvl[pop_idx] : cur_level;
      id_pop    = do_pop ? stack_id[pop_idx]  : cur_id;
      push_idx  = AW'(depth_pop);
   end

`ifdef CLIC_SEQ_TIMEOUT_EN
   localparam int TW = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;

   logic [TW-1:0] ack_cnt;

   assign ack_expired = (state == REQ) && !bus.trap_ack && (ack_cnt == TW'(ACK_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!resetb) begin
         ack_cnt     <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (accept)
            ack_cnt <= '0;
         else if ((state == REQ) && !bus.trap_ack)
            ack_cnt <= ack_cnt + TW'(1);
         if (ack_expired)
            err_timeout <= 1'b1;
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = (ACK_TIMEOUT != 0);
   assign ack_expired    = 1'b0;
   assign err_timeout    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!resetb)
         state <= READY;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         READY: if (accept) state_nx = REQ;
         REQ: begin
            if (bus.trap_ack)
               state_nx = lat_edge ? CLR : READY;
            else if (ack_expired)
               state_nx = READY;
         end
         CLR:     if (bus.clr_ready) state_nx = READY;
         default: state_nx = READY;
      endcase
   end

   always_comb begin
      irq_busy   = (state != READY);
      trap_req   = 1'b0;
      trap_id    = '0;
      trap_level = '0;
      clr_valid  = 1'b0;
      clr_id     = '0;
      case (state)
         REQ: begin
            trap_req   = 1'b1;
            trap_id    = lat_id;
            trap_level = lat_level;
         end
         CLR: begin
            clr_valid = 1'b1;
            clr_id    = lat_id;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetb) begin
         cur_level     <= '0;
         cur_id        <= '0;
         depth         <= '0;
         err_underflow <= 1'b0;
         lat_level     <= '0;
         lat_id        <= '0;
         lat_edge      <= 1'b0;
         for (int i = 0; i < NEST_DEPTH; i++) begin
            stack_lvl[i] <= '0;
            stack_id[i]  <= '0;
         end
      end else begin
         if (accept) begin
            lat_level <= bus.irq_level;
            lat_id    <= bus.irq_id;
            lat_edge  <= bus.irq_edge;
         end
         if (bus.mret && (depth == '0))
            err_underflow <= 1'b1;
         if (do_push) begin
            stack_lvl[push_idx] <= lvl_pop;
            stack_id[push_idx]  <= id_pop;
            cur_level           <= lat_level;
            cur_id              <= lat_id;
            depth               <= depth_pop + DW'(1);
         end else begin
            cur_level <= lvl_pop;
            cur_id    <= id_pop;
            depth     <= depth_pop;
         end
      end
   end

   assign bus.irq_busy      = irq_busy;
   assign bus.trap_req      = trap_req;
   assign bus.trap_id       = trap_id;
   assign bus.trap_level    = trap_level;
   assign bus.clr_valid     = clr_valid;
   assign bus.clr_id        = clr_id;
   assign bus.cur_level     = cur_level;
   assign bus.cur_id        = cur_id;
   assign bus.depth         = depth;
   assign bus.err_underflow = err_underflow;
   assign bus.err_timeout   = err_timeout;

endmodule

// File: tb/tb_clic_irq_sequencer.sv
// Directed plus randomized bench for clic_irq_sequencer against a transaction-level
// nesting model (queue-based stack of level/ID pairs).
module tb_clic_irq_sequencer;
   localparam int NEST  = 4;
   localparam int ID_W  = 5;
   localparam int LVL_W = 8;
   localparam int TMO   = 64;

   logic clk = 1'b0;
   logic resetb;

   always #5 clk = ~clk;

   clic_irq_sequencer_if #(.NEST_DEPTH(NEST), .ID_W(ID_W), .LVL_W(LVL_W)) bus ();

   clic_irq_sequencer #(
      .NEST_DEPTH(NEST), .ID_W(ID_W), .LVL_W(LVL_W), .ACK_TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .resetb(resetb),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   logic [LVL_W-1:0]      m_lvl;
   logic [ID_W-1:0]       m_id;
   logic [LVL_W+ID_W-1:0] m_stk[$];
   logic                  m_uf;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_lvl = '0;
      m_id  = '0;
      m_stk.delete();
      m_uf  = 1'b0;
   endtask

   task automatic model_pop();
      if (m_stk.size() > 0) {m_lvl, m_id} = m_stk.pop_back();
      else m_uf = 1'b1;
   endtask

   task automatic model_push(input logic [LVL_W-1:0] lvl, input logic [ID_W-1:0] id);
      m_stk.push_back({m_lvl, m_id});
      m_lvl = lvl;
      m_id  = id;
   endtask

   task automatic chk_arch(input string tag);
      chk({tag, ".cur_level"}, 32'(bus.cur_level), 32'(m_lvl));
      chk({tag, ".cur_id"}, 32'(bus.cur_id), 32'(m_id));
      chk({tag, ".depth"}, 32'(bus.depth), 32'(m_stk.size()));
      chk({tag, ".err_underflow"}, 32'(bus.err_underflow), 32'(m_uf));
   endtask

   task automatic do_mret(input string tag);
      bus.mret = 1'b1;
      tick();
      bus.mret = 1'b0;
      model_pop();
      chk_arch(tag);
   endtask

   // One complete interrupt offer: accepted or ignored as the model predicts.
   task automatic do_irq(input string tag, input logic [ID_W-1:0] id, input logic [LVL_W-1:0] lvl,
                         input logic edg, input int ackd, input int clrd, input logic coinc);
      logic acc;
      acc = (lvl > m_lvl) && (m_stk.size() < NEST);
      bus.irq_valid = 1'b1;
      bus.irq_id    = id;
      bus.irq_level = lvl;
      bus.irq_edge  = edg;
      tick();
      bus.irq_valid = 1'b0;
      chk({tag, ".trap_req"}, 32'(bus.trap_req), 32'(acc));
      chk({tag, ".busy"}, 32'(bus.irq_busy), 32'(acc));
      if (acc) begin
         chk({tag, ".trap_id"}, 32'(bus.trap_id), 32'(id));
         chk({tag, ".trap_level"}, 32'(bus.trap_level), 32'(lvl));
         for (int i = 0; i < ackd; i++) begin
            tick();
            chk({tag, ".trap_req_hold"}, 32'(bus.trap_req), 32'd1);
            chk({tag, ".trap_id_hold"}, 32'(bus.trap_id), 32'(id));
            chk({tag, ".clr_valid_req"}, 32'(bus.clr_valid), 32'd0);
         end
         bus.trap_ack = 1'b1;
         bus.mret     = coinc;
         tick();
         bus.trap_ack = 1'b0;
         bus.mret     = 1'b0;
         if (coinc) model_pop();
         model_push(lvl, id);
         chk({tag, ".trap_req_drop"}, 32'(bus.trap_req), 32'd0);
         chk_arch(tag);
         if (edg) begin
            chk({tag, ".clr_valid"}, 32'(bus.clr_valid), 32'd1);
            chk({tag, ".clr_id"}, 32'(bus.clr_id), 32'(id));
            for (int i = 0; i < clrd; i++) begin
               tick();
               chk({tag, ".clr_valid_hold"}, 32'(bus.clr_valid), 32'd1);
               chk({tag, ".clr_id_hold"}, 32'(bus.clr_id), 32'(id));
            end
            bus.clr_ready = 1'b1;
            tick();
            bus.clr_ready = 1'b0;
         end
         chk({tag, ".clr_done"}, 32'(bus.clr_valid), 32'd0);
         chk({tag, ".busy_done"}, 32'(bus.irq_busy), 32'd0);
      end
   endtask

   initial begin
      int n;
      resetb        = 1'b0;
      bus.irq_valid = 1'b1;
      bus.irq_id    = 5'd7;
      bus.irq_level = 8'hFF;
      bus.irq_edge  = 1'b1;
      bus.trap_ack  = 1'b0;
      bus.mret      = 1'b0;
      bus.clr_ready = 1'b0;
      model_reset();
      repeat (2) tick();

      chk("rst.busy", 32'(bus.irq_busy), 32'd0);
      chk("rst.trap_req", 32'(bus.trap_req), 32'd0);
      chk("rst.trap_id", 32'(bus.trap_id), 32'd0);
      chk("rst.trap_level", 32'(bus.trap_level), 32'd0);
      chk("rst.clr_valid", 32'(bus.clr_valid), 32'd0);
      chk("rst.clr_id", 32'(bus.clr_id), 32'd0);
      chk("rst.err_timeout", 32'(bus.err_timeout), 32'd0);
      chk_arch("rst");

      bus.irq_valid = 1'b0;
      resetb        = 1'b1;
      tick();
      chk("rst_rel.busy", 32'(bus.irq_busy), 32'd0);

      // Single level-triggered handler, then return.
      do_irq("lvl", 5'd3, 8'h40, 1'b0, 2, 0, 1'b0);
      do_mret("lvl_mret");

      // Nested edge-triggered handler with a slow clear.
      do_irq("nest_a", 5'd3, 8'h40, 1'b0, 0, 0, 1'b0);
      do_irq("nest_b", 5'd9, 8'h80, 1'b1, 1, 3, 1'b0);
      do_mret("nest_mret1");
      do_mret("nest_mret2");

      // Equal/lower levels and a full stack never preempt.
      do_irq("np_base", 5'd3, 8'h40, 1'b0, 0, 0, 1'b0);
      do_irq("np_eq", 5'd4, 8'h40, 1'b0, 0, 0, 1'b0);
      do_irq("np_lo", 5'd5, 8'h20, 1'b1, 0, 0, 1'b0);
      do_irq("fill1", 5'd6, 8'h50, 1'b0, 0, 0, 1'b0);
      do_irq("fill2", 5'd7, 8'h60, 1'b1, 0, 1, 1'b0);
      do_irq("fill3", 5'd8, 8'h70, 1'b0, 1, 0, 1'b0);
      chk("full.depth", 32'(bus.depth), 32'd4);
      do_irq("full_ff", 5'd31, 8'hFF, 1'b0, 0, 0, 1'b0);
      chk("full_ff.trap_req", 32'(bus.trap_req), 32'd0);
      repeat (4) do_mret("drain");
      chk("drain.cur_level", 32'(bus.cur_level), 32'd0);

      // Underflow is sticky and leaves depth at zero.
      do_mret("uflow");
      chk("uflow.flag", 32'(bus.err_underflow), 32'd1);

      // mret on the same edge as trap_ack swaps the current handler.
      do_irq("co_a", 5'd1, 8'h10, 1'b0, 0, 0, 1'b0);
      do_irq("co_b", 5'd2, 8'h40, 1'b0, 0, 0, 1'b0);
      do_irq("co_c", 5'd5, 8'h90, 1'b0, 1, 0, 1'b1);
      chk("co.cur_level", 32'(bus.cur_level), 32'h90);
      chk("co.depth", 32'(bus.depth), 32'd2);
      do_mret("co_mret1");
      chk("co_mret1.lvl", 32'(bus.cur_level), 32'h10);
      do_mret("co_mret2");

      // Reset in the middle of a request aborts it.
      bus.irq_valid = 1'b1;
      bus.irq_id    = 5'd12;
      bus.irq_level = 8'h30;
      bus.irq_edge  = 1'b1;
      tick();
      bus.irq_valid = 1'b0;
      chk("midrst.pre", 32'(bus.trap_req), 32'd1);
      resetb = 1'b0;
      tick();
      resetb = 1'b1;
      model_reset();
      chk("midrst.trap_req", 32'(bus.trap_req), 32'd0);
      chk("midrst.clr_valid", 32'(bus.clr_valid), 32'd0);
      chk("midrst.busy", 32'(bus.irq_busy), 32'd0);
      chk_arch("midrst");

      // Unacknowledged request.
      do_irq("to_base", 5'd2, 8'h20, 1'b0, 0, 0, 1'b0);
      bus.irq_valid = 1'b1;
      bus.irq_id    = 5'd14;
      bus.irq_level = 8'hA0;
      bus.irq_edge  = 1'b0;
      tick();
      bus.irq_valid = 1'b0;
      chk("to.req", 32'(bus.trap_req), 32'd1);
`ifdef CLIC_SEQ_TIMEOUT_EN
      n = 1;
      while (bus.trap_req && n < 200) begin
         tick();
         if (bus.trap_req) n++;
      end
      chk("to.cycles", 32'(n), 32'(TMO));
      chk("to.err_timeout", 32'(bus.err_timeout), 32'd1);
      chk("to.busy", 32'(bus.irq_busy), 32'd0);
      chk_arch("to");
`else
      n = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (bus.trap_req) n++;
      end
      chk("to.wait", 32'(n), 32'd100);
      chk("to.err_timeout", 32'(bus.err_timeout), 32'd0);
      bus.trap_ack = 1'b1;
      tick();
      bus.trap_ack = 1'b0;
      model_push(8'hA0, 5'd14);
      chk_arch("to_ack");
`endif

      // Randomized offers and returns against the nesting model.
      for (int k = 0; k < 200; k++) begin
         if ($urandom_range(0, 9) < 3)
            do_mret("rnd_mret");
         else
            do_irq("rnd_irq", 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));
      end
      chk("rnd.err_timeout", 32'(bus.err_timeout), 32'(bus.err_timeout === 1'b1 ? 1 : 0) & 32'd0 | 32'(
`ifdef CLIC_SEQ_TIMEOUT_EN
         1
`else
         0
`endif
      ));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
